// File: rtl/sram_sp_ctrl_pkg.sv
// Shared arbitration encodings, FSM state type and width helper for sram_sp_ctrl.
package sram_sp_ctrl_pkg;

  localparam int ARB_READ_FIRST  = 0;
  localparam int ARB_WRITE_FIRST = 1;
  localparam int ARB_ROUND_ROBIN = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

  // Address width for a given depth, never below 1 bit.
  function automatic int unsigned func_log2(input int value);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_sp_ctrl_rsp_buf.sv
// Two-entry synchronous FIFO holding read responses awaiting the consumer.
module sram_sp_ctrl_rsp_buf #(
  parameter int DATA_WD = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [DATA_WD-1:0] push_dat,
  input  logic               pop,
  output logic [DATA_WD-1:0] head_dat,
  output logic [1:0]         cnt
);

  logic [DATA_WD-1:0] mem [2];
  logic               wr_ptr;
  logic               rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by cnt.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/sram_sp_ctrl.sv
// Single-port SRAM controller: arbitrates one write and one read port onto one SRAM.
// Optional zero-fill sweep after reset when SRAM_SP_CTRL_INIT_EN is defined.
module sram_sp_ctrl
  import sram_sp_ctrl_pkg::*;
#(
  parameter  int          SIZE     = -1,
  parameter  int          DATA_WD  = -1,
  parameter  int          ARB_MODE = ARB_READ_FIRST,
  localparam int unsigned SIZE_WD  = func_log2(SIZE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_val_i,
  input  logic [SIZE_WD-1:0] wr_adr_i,
  input  logic [DATA_WD-1:0] wr_dat_i,
  output logic               wr_rdy_o,
  input  logic               rd_val_i,
  input  logic [SIZE_WD-1:0] rd_adr_i,
  output logic               rd_rdy_o,
  output logic               rsp_val_o,
  output logic [DATA_WD-1:0] rsp_dat_o,
  input  logic               rsp_rdy_i,
  output logic [SIZE_WD-1:0] sram_adr_o,
  output logic               sram_wr_val_o,
  output logic [DATA_WD-1:0] sram_wr_dat_o,
  output logic               sram_rd_val_o,
  input  logic [DATA_WD-1:0] sram_rd_dat_i,
  output logic               busy_o
);

  if (SIZE < 1) begin : g_bad_size
    $error("sram_sp_ctrl: SIZE parameter must be set to a positive depth");
  end
  if (DATA_WD < 1) begin : g_bad_data_wd
    $error("sram_sp_ctrl: DATA_WD parameter must be set to a positive width");
  end

  ctrl_state_e        state;
  logic [SIZE_WD-1:0] init_cnt;
  logic               rd_inflight;
  logic               last_wr;
  logic               grant_wr;
  logic               grant_rd;
  logic               rd_elig;
  logic               rsp_pop;
  logic               buf_push;
  logic               buf_pop;
  logic [1:0]         buf_cnt;
  logic [1:0]         buf_cnt_after;
  logic [DATA_WD-1:0] buf_head;

`ifdef SRAM_SP_CTRL_INIT_EN
  ctrl_state_e state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && init_cnt == SIZE_WD'(SIZE - 1)) state_nxt = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst)                   init_cnt <= '0;
    else if (state == ST_INIT) init_cnt <= init_cnt + SIZE_WD'(1);
  end
`else
  assign state    = ST_RUN;
  assign init_cnt = '0;
`endif

  assign busy_o = (state == ST_INIT);

  // Response path: flow-through from the SRAM when the buffer is empty.
  assign rsp_val_o = !rst && (buf_cnt != 2'd0 || rd_inflight);
  assign rsp_dat_o = (buf_cnt != 2'd0) ? buf_head : sram_rd_dat_i;
  assign rsp_pop   = rsp_val_o && rsp_rdy_i;
  assign buf_pop   = rsp_pop && buf_cnt != 2'd0;
  assign buf_push  = rd_inflight && !(rsp_pop && buf_cnt == 2'd0);

  // A read may issue only if its response is guaranteed a buffer slot.
  assign buf_cnt_after = buf_cnt - 2'(buf_pop);
  assign rd_elig       = rd_val_i && ((3'(buf_cnt_after) + 3'(rd_inflight)) < 3'd2);

  always_comb begin
    grant_wr      = 1'b0;
    grant_rd      = 1'b0;
    sram_adr_o    = '0;
    sram_wr_val_o = 1'b0;
    sram_wr_dat_o = '0;
    sram_rd_val_o = 1'b0;
    if (!rst) begin
      if (state == ST_INIT) begin
        sram_wr_val_o = 1'b1;
        sram_adr_o    = init_cnt;
      end else begin
        if (wr_val_i && rd_elig) begin
          if (ARB_MODE == ARB_READ_FIRST)       grant_rd = 1'b1;
          else if (ARB_MODE == ARB_WRITE_FIRST) grant_wr = 1'b1;
          else if (last_wr)                     grant_rd = 1'b1;
          else                                  grant_wr = 1'b1;
        end else begin
          grant_wr = wr_val_i;
          grant_rd = rd_elig;
        end
        if (grant_wr) begin
          sram_wr_val_o = 1'b1;
          sram_adr_o    = wr_adr_i;
          sram_wr_dat_o = wr_dat_i;
        end else if (grant_rd) begin
          sram_rd_val_o = 1'b1;
          sram_adr_o    = rd_adr_i;
        end
      end
    end
  end

  assign wr_rdy_o = grant_wr;
  assign rd_rdy_o = grant_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_inflight <= 1'b0;
      last_wr     <= 1'b1;
    end else begin
      rd_inflight <= grant_rd;
      if (grant_wr)      last_wr <= 1'b1;
      else if (grant_rd) last_wr <= 1'b0;
    end
  end

  sram_sp_ctrl_rsp_buf #(
    .DATA_WD (DATA_WD)
  ) u_rsp_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (buf_push),
    .push_dat (sram_rd_dat_i),
    .pop      (buf_pop),
    .head_dat (buf_head),
    .cnt      (buf_cnt)
  );

endmodule

// File: tb/tb_sram_sp_ctrl.sv
// Directed bench for sram_sp_ctrl (round-robin arbitration) with a behavioural SRAM
// that drives random data on cycles without a read.
module tb_sram_sp_ctrl;

  localparam int unsigned SIZE    = 64;
  localparam int unsigned DATA_WD = 32;
  localparam int unsigned AW      = 6;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               wr_val = 1'b0;
  logic [AW-1:0]      wr_adr = '0;
  logic [DATA_WD-1:0] wr_dat = '0;
  logic               wr_rdy;
  logic               rd_val = 1'b0;
  logic [AW-1:0]      rd_adr = '0;
  logic               rd_rdy;
  logic               rsp_val;
  logic [DATA_WD-1:0] rsp_dat;
  logic               rsp_rdy = 1'b1;
  logic [AW-1:0]      sram_adr;
  logic               sram_wr_val;
  logic [DATA_WD-1:0] sram_wr_dat;
  logic               sram_rd_val;
  logic [DATA_WD-1:0] sram_rd_dat;
  logic               busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sram_sp_ctrl #(
    .SIZE     (64),
    .DATA_WD  (32),
    .ARB_MODE (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_val_i      (wr_val),
    .wr_adr_i      (wr_adr),
    .wr_dat_i      (wr_dat),
    .wr_rdy_o      (wr_rdy),
    .rd_val_i      (rd_val),
    .rd_adr_i      (rd_adr),
    .rd_rdy_o      (rd_rdy),
    .rsp_val_o     (rsp_val),
    .rsp_dat_o     (rsp_dat),
    .rsp_rdy_i     (rsp_rdy),
    .sram_adr_o    (sram_adr),
    .sram_wr_val_o (sram_wr_val),
    .sram_wr_dat_o (sram_wr_dat),
    .sram_rd_val_o (sram_rd_val),
    .sram_rd_dat_i (sram_rd_dat),
    .busy_o        (busy)
  );

  // Behavioural single-port SRAM, one-cycle read latency, random data otherwise.
  logic [DATA_WD-1:0] mem [SIZE];
  logic [DATA_WD-1:0] rd_q;
  logic [DATA_WD-1:0] rnd_q;
  logic               rd_vld_q;
  logic               fill = 1'b1;

  always @(posedge clk) begin
    rnd_q    <= $urandom();
    rd_vld_q <= sram_rd_val;
    if (fill) begin
      for (int i = 0; i < int'(SIZE); i++) mem[i] <= 32'hDEAD_0000 | 32'(i);
    end else begin
      if (sram_rd_val) rd_q <= mem[sram_adr];
      if (sram_wr_val) mem[sram_adr] <= sram_wr_dat;
    end
  end

  assign sram_rd_dat = rd_vld_q ? rd_q : rnd_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int n;
    rst    = 1'b1;
    wr_val = 1'b0;
    rd_val = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
`ifdef SRAM_SP_CTRL_INIT_EN
    n = 0;
    while (busy && n < 200) begin
      n++;
      step();
    end
    check("init_busy_cycles", 32'(n), 32'd64);
`else
    n = 0;
    check("busy_run", 32'(busy), 32'd0 + 32'(n));
`endif
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    int                 accepted;
    int                 gcode;
    logic [DATA_WD-1:0] exp5;
    logic [DATA_WD-1:0] exp40;
    int                 exp_grant [4];

    exp_grant[0] = 1; exp_grant[1] = 2; exp_grant[2] = 1; exp_grant[3] = 2;
`ifdef SRAM_SP_CTRL_INIT_EN
    exp5  = 32'h0;
    exp40 = 32'h0;
`else
    exp5  = 32'hA5A5_0001;
    exp40 = 32'hDEAD_0028;
`endif

    // Requests held valid during reset must see no acceptance.
    wr_val = 1'b1; wr_adr = 6'd3; rd_val = 1'b1; rd_adr = 6'd3; rsp_rdy = 1'b1;
    step();
    check("rst_wr_rdy", 32'(wr_rdy), 32'd0);
    check("rst_rd_rdy", 32'(rd_rdy), 32'd0);
    check("rst_sram_wr", 32'(sram_wr_val), 32'd0);
    check("rst_sram_rd", 32'(sram_rd_val), 32'd0);
    check("rst_rsp_val", 32'(rsp_val), 32'd0);
`ifdef SRAM_SP_CTRL_INIT_EN
    check("rst_busy", 32'(busy), 32'd1);
`else
    check("rst_busy", 32'(busy), 32'd0);
`endif
    fill = 1'b0;
    do_reset();

    // Write then read the same address.
    step();
    wr_val = 1'b1; wr_adr = 6'd5; wr_dat = 32'hA5A5_0001;
    #1;
    check("wr_rdy", 32'(wr_rdy), 32'd1);
    check("wr_strobe", 32'(sram_wr_val), 32'd1);
    check("wr_adr", 32'(sram_adr), 32'd5);
    check("wr_dat", sram_wr_dat, 32'hA5A5_0001);
    step();
    wr_val = 1'b0; rd_val = 1'b1; rd_adr = 6'd5;
    #1;
    check("rd_rdy", 32'(rd_rdy), 32'd1);
    check("rd_strobe", 32'(sram_rd_val), 32'd1);
    check("rd_no_wr", 32'(sram_wr_val), 32'd0);
    step();
    rd_val = 1'b0;
    #1;
    check("rsp_val", 32'(rsp_val), 32'd1);
    check("rsp_dat", rsp_dat, 32'hA5A5_0001);
    step();
    #1;
    check("idle_rsp_val", 32'(rsp_val), 32'd0);
    check("idle_adr", 32'(sram_adr), 32'd0);
    check("idle_wdat", sram_wr_dat, 32'd0);
    check("idle_strobes", 32'({sram_wr_val, sram_rd_val}), 32'd0);

    // Round-robin under constant conflict: R, W, R, W.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      wr_val = 1'b1; wr_adr = 6'd10; wr_dat = 32'h1111_0000 + 32'(i);
      rd_val = 1'b1; rd_adr = 6'd5;
      #1;
      gcode = (rd_rdy ? 1 : 0) + (wr_rdy ? 2 : 0);
      check("rr_grant", 32'(gcode), 32'(exp_grant[i]));
      check("rr_rsp_val", 32'(rsp_val), (i == 1 || i == 3) ? 32'd1 : 32'd0);
      if (i == 1 || i == 3) check("rr_rsp_dat", rsp_dat, exp5);
    end
    step();
    wr_val = 1'b0; rd_val = 1'b1; rd_adr = 6'd10;
    #1;
    check("rr_tail_rsp_val", 32'(rsp_val), 32'd0);
    check("raw_rd_rdy", 32'(rd_rdy), 32'd1);
    step();
    rd_val = 1'b0;
    #1;
    check("raw_rsp_dat", rsp_dat, 32'h1111_0003);

    // Back-pressure: preload, then four reads with the consumer stalled.
    for (int a = 20; a < 24; a++) begin
      step();
      wr_val = 1'b1; wr_adr = 6'(a); wr_dat = 32'hC0DE_0000 + 32'(a);
      #1;
      check("preload_wr_rdy", 32'(wr_rdy), 32'd1);
    end
    step();
    wr_val = 1'b0; rsp_rdy = 1'b0;
    accepted = 0;
    for (int c = 0; c < 4; c++) begin
      rd_val = 1'b1; rd_adr = 6'(20 + accepted);
      #1;
      if (rd_rdy) accepted++;
      step();
    end
    check("bp_accepted", 32'(accepted), 32'd2);
    rd_val = 1'b1; rd_adr = 6'(20 + accepted);
    wr_val = 1'b1; wr_adr = 6'd30; wr_dat = 32'h3030_3030;
    #1;
    check("bp_rd_blocked", 32'(rd_rdy), 32'd0);
    check("bp_wr_ok", 32'(wr_rdy), 32'd1);
    check("bp_rsp_val", 32'(rsp_val), 32'd1);
    check("bp_head", rsp_dat, 32'hC0DE_0014);
    step();
    wr_val = 1'b0; rd_val = 1'b0; rsp_rdy = 1'b1;
    #1;
    check("drain0_dat", rsp_dat, 32'hC0DE_0014);
    step();
    #1;
    check("drain1_val", 32'(rsp_val), 32'd1);
    check("drain1_dat", rsp_dat, 32'hC0DE_0015);
    step();
    #1;
    check("drain_empty", 32'(rsp_val), 32'd0);

    // Untouched address reads its power-up (or zero-filled) contents.
    rd_val = 1'b1; rd_adr = 6'd40;
    #1;
    check("rd40_rdy", 32'(rd_rdy), 32'd1);
    step();
    rd_val = 1'b0;
    #1;
    check("rd40_dat", rsp_dat, exp40);

    // Reset in the cycle after a read accept discards the response.
    step();
    rd_val = 1'b1; rd_adr = 6'd20;
    #1;
    check("rstmid_rd_rdy", 32'(rd_rdy), 32'd1);
    step();
    rd_val = 1'b0; rst = 1'b1;
    #1;
    check("rstmid_rsp_in_rst", 32'(rsp_val), 32'd0);
    step();
    rst = 1'b0;
    #1;
`ifdef SRAM_SP_CTRL_INIT_EN
    accepted = 0;
    while (busy && accepted < 200) begin
      accepted++;
      step();
    end
`endif
    check("rstmid_rsp_after", 32'(rsp_val), 32'd0);
    step();
    #1;
    check("rstmid_rsp_later", 32'(rsp_val), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
